// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts per-neuron spikes over a programmable window
// and reports counts, the winning neuron and a saturation flag.
// Optional feature macro: SPIKE_RATE_DECODER_DROP_CNT_EN adds the `dropped`
// counter of spikes that arrive while a result is being held.
module spike_rate_decoder #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       spikes_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic             enable,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic [1:0]       winner,
    output logic             overflow,
    output logic             busy
`ifdef SPIKE_RATE_DECODER_DROP_CNT_EN
    ,
    output logic [7:0]       dropped
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [2:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIN_W-1:0]            rem_q, rem_d;
    logic                        ovf_q, ovf_d;
    logic [1:0]                  win_q, win_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        start_c;
    logic                        load_c;
    logic                        last_c;

    // Highest count wins, ties resolve to the lowest index, all zero gives 3.
    function automatic logic [1:0] pick_winner(input logic [2:0][CNT_W-1:0] c);
        logic [1:0]       w;
        logic [CNT_W-1:0] best;
        w    = 2'd3;
        best = '0;
        for (int i = 0; i < 3; i++) begin
            if (c[i] > best) begin
                best = c[i];
                w    = 2'(i);
            end
        end
        return w;
    endfunction

    assign start_c = enable && (win_len != '0);
    assign last_c  = (rem_q == WIN_W'(1));
    assign load_c  = start_c && ((state_q == IDLE) || ((state_q == HOLD) && result_ready));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; HOLD can restart directly for back-to-back windows.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_c) state_d = COUNT;
            COUNT: begin
                if (!enable)     state_d = IDLE;
                else if (last_c) state_d = HOLD;
            end
            HOLD:    if (result_ready) state_d = start_c ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: window load, saturating accumulate, result handshake.
    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        if (load_c) begin
            cnt_d   = '0;
            ovf_d   = 1'b0;
            rem_d   = win_len;
            valid_d = 1'b0;
        end else if ((state_q == COUNT) && enable) begin
            for (int i = 0; i < 3; i++) begin
                if (spikes_in[i]) begin
                    if (cnt_q[i] == CNT_MAX) ovf_d    = 1'b1;
                    else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            rem_d = rem_q - WIN_W'(1);
            if (last_c) valid_d = 1'b1;
        end else if ((state_q == HOLD) && result_ready) begin
            valid_d = 1'b0;
        end
        win_d  = pick_winner(cnt_d);
        busy_d = (state_d == COUNT);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            win_q   <= 2'd3;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign result_valid = valid_q;
    assign count0       = cnt_q[0];
    assign count1       = cnt_q[1];
    assign count2       = cnt_q[2];
    assign winner       = win_q;
    assign overflow     = ovf_q;
    assign busy         = busy_q;

`ifdef SPIKE_RATE_DECODER_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    // Saturating count of held-result edges that saw any spike.
    always_comb begin
        drop_d = drop_q;
        if ((state_q == HOLD) && (spikes_in != 3'd0) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_q <= 8'd0;
        else       drop_q <= drop_d;
    end

    assign dropped = drop_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (CNT_W=8 and CNT_W=4) share
// directed stimulus; a window-level model is checked every cycle, plus
// hand-computed literal expectations.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] spikes_in = 3'd0;
    logic [7:0] win_len = 8'd0;
    logic       enable = 1'b0;
    logic       result_ready = 1'b0;

    logic       a_valid, b_valid, a_ovf, b_ovf, a_busy, b_busy;
    logic [7:0] a_c0, a_c1, a_c2;
    logic [3:0] b_c0, b_c1, b_c2;
    logic [1:0] a_win, b_win;
`ifdef SPIKE_RATE_DECODER_DROP_CNT_EN
    logic [7:0] a_drop, b_drop;
`endif

    int checks = 0;
    int failures = 0;

    // Model: raw (unbounded) spike totals of the current/last window
    int m_phase = 0;   // 0 idle, 1 window running, 2 result held
    int m_raw[3];
    int m_len = 0;
    int m_samp = 0;
    int m_valid = 0;
    int m_known = 1;   // counts/winner/overflow are defined
    int m_drop = 0;

    always #5 clk = ~clk;

    spike_rate_decoder u_a (
        .clk(clk), .reset(reset), .spikes_in(spikes_in), .win_len(win_len),
        .enable(enable), .result_ready(result_ready), .result_valid(a_valid),
        .count0(a_c0), .count1(a_c1), .count2(a_c2), .winner(a_win),
        .overflow(a_ovf), .busy(a_busy)
`ifdef SPIKE_RATE_DECODER_DROP_CNT_EN
        , .dropped(a_drop)
`endif
    );

    spike_rate_decoder #(.CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .spikes_in(spikes_in), .win_len(win_len),
        .enable(enable), .result_ready(result_ready), .result_valid(b_valid),
        .count0(b_c0), .count1(b_c1), .count2(b_c2), .winner(b_win),
        .overflow(b_ovf), .busy(b_busy)
`ifdef SPIKE_RATE_DECODER_DROP_CNT_EN
        , .dropped(b_drop)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input int r, input int mx);
        return (r > mx) ? mx : r;
    endfunction

    function automatic int best_of(input int c0, input int c1, input int c2);
        int w = 3;
        if (c0 > 0) w = 0;
        if (c1 > 0 && (w == 3 || c1 > c0)) w = 1;
        if (c2 > 0 && (w == 3 || (w == 0 && c2 > c0) || (w == 1 && c2 > c1))) w = 2;
        return w;
    endfunction

    task automatic model_start();
        m_phase = 1;
        m_raw   = '{0, 0, 0};
        m_samp  = 0;
        m_len   = int'(win_len);
        m_known = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            m_phase = 0; m_raw = '{0, 0, 0}; m_len = 0; m_samp = 0;
            m_valid = 0; m_known = 1; m_drop = 0;
        end else begin
            if (m_phase == 2 && spikes_in != 3'd0 && m_drop < 255) m_drop++;
            case (m_phase)
                0: if (enable && win_len != 8'd0) model_start();
                1: begin
                    if (!enable) begin
                        m_phase = 0; m_known = 0;
                    end else begin
                        for (int i = 0; i < 3; i++) m_raw[i] += int'(spikes_in[i]);
                        m_samp++;
                        if (m_samp == m_len) begin
                            m_phase = 2; m_valid = 1; m_known = 1;
                        end
                    end
                end
                default: begin
                    if (result_ready) begin
                        m_valid = 0;
                        if (enable && win_len != 8'd0) model_start();
                        else m_phase = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_inst(input string tag, input int v, input int bz,
                              input int c0, input int c1, input int c2,
                              input int w, input int o, input int mx);
        int e0, e1, e2;
        chk({tag, ".result_valid"}, v, m_valid);
        chk({tag, ".busy"}, bz, (m_phase == 1) ? 1 : 0);
        if (m_known != 0) begin
            e0 = sat(m_raw[0], mx); e1 = sat(m_raw[1], mx); e2 = sat(m_raw[2], mx);
            chk({tag, ".count0"}, c0, e0);
            chk({tag, ".count1"}, c1, e1);
            chk({tag, ".count2"}, c2, e2);
            chk({tag, ".winner"}, w, best_of(e0, e1, e2));
            chk({tag, ".overflow"}, o,
                (m_raw[0] > mx || m_raw[1] > mx || m_raw[2] > mx) ? 1 : 0);
        end
    endtask

    task automatic compare();
        check_inst("A", a_valid, a_busy, a_c0, a_c1, a_c2, a_win, a_ovf, 255);
        check_inst("B", b_valid, b_busy, b_c0, b_c1, b_c2, b_win, b_ovf, 15);
`ifdef SPIKE_RATE_DECODER_DROP_CNT_EN
        chk("A.dropped", a_drop, m_drop);
        chk("B.dropped", b_drop, m_drop);
`endif
    endtask

    // One clock: model advances on the edge, DUT compared half a cycle later.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic release_result();
        result_ready = 1'b1; enable = 1'b0; spikes_in = 3'd0;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, ".valid"}, a_valid, 0);
        chk({nm, ".busy"}, a_busy, 0);
        chk({nm, ".count0"}, a_c0, 0);
        chk({nm, ".count2"}, a_c2, 0);
        chk({nm, ".winner"}, a_win, 3);
        chk({nm, ".overflow"}, a_ovf, 0);
        chk({nm, ".b_count1"}, b_c1, 0);
        chk({nm, ".b_valid"}, b_valid, 0);
    endtask

    initial begin
        int first;
        int last_v;
        int pulses;

        // Reset
        m_raw = '{0, 0, 0};
        reset = 1'b1;
        tick(); tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // Window of 10: neuron0 every sample, neuron2 on four samples
        enable = 1'b1; win_len = 8'd10;
        tick();
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            spikes_in = (k % 2 == 0 && k <= 8) ? 3'b101 : 3'b001;
            tick();
            if (a_valid && first < 0) first = k;
        end
        chk("t34.latency", first, 10);
        result_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            spikes_in = 3'(k + 1);
            tick();
        end
        chk("t34.valid_held", a_valid, 1);
        chk("t34.count0", a_c0, 10);
        chk("t34.count1", a_c1, 0);
        chk("t34.count2", a_c2, 4);
        chk("t34.winner", a_win, 0);
        chk("t34.overflow", a_ovf, 0);
        release_result();

        // Tie between neurons 1 and 2 at 7, neuron0 at 3
        enable = 1'b1; win_len = 8'd10; spikes_in = 3'd0;
        tick();
        for (int k = 1; k <= 10; k++) begin
            spikes_in = (k <= 3) ? 3'b111 : (k <= 7) ? 3'b110 : 3'b000;
            tick();
        end
        chk("t35.count0", a_c0, 3);
        chk("t35.count1", a_c1, 7);
        chk("t35.count2", a_c2, 7);
        chk("t35.winner", a_win, 1);
        release_result();

        // Window with no spikes
        enable = 1'b1; win_len = 8'd4; spikes_in = 3'd0;
        for (int k = 0; k <= 4; k++) tick();
        chk("t35z.valid", a_valid, 1);
        chk("t35z.winner", a_win, 3);
        chk("t35z.count1", a_c1, 0);
        chk("t35z.b_winner", b_win, 3);
        release_result();

        // Saturation: 255 samples fit in 8 bits, not in 4 bits
        enable = 1'b1; win_len = 8'd255; spikes_in = 3'b010;
        for (int k = 0; k <= 255; k++) tick();
        chk("t36.a_count1", a_c1, 255);
        chk("t36.a_overflow", a_ovf, 0);
        chk("t36.b_count1", b_c1, 15);
        chk("t36.b_overflow", b_ovf, 1);
        release_result();
        enable = 1'b1; win_len = 8'd20; spikes_in = 3'b010;
        for (int k = 0; k <= 20; k++) tick();
        chk("t36b.b_count1", b_c1, 15);
        chk("t36b.b_overflow", b_ovf, 1);
        chk("t36b.a_count1", a_c1, 20);
        chk("t36b.a_overflow", a_ovf, 0);
        release_result();

        // Back-to-back windows of 5 with the consumer always ready
        enable = 1'b1; win_len = 8'd5; result_ready = 1'b1;
        last_v = -1; pulses = 0;
        for (int t = 0; t < 30; t++) begin
            spikes_in = 3'(t);
            tick();
            if (a_valid) begin
                pulses++;
                if (last_v >= 0) chk("t37.spacing", t - last_v, 6);
                last_v = t;
            end
        end
        chk("t37.pulses", pulses, 5);
        tick(); tick(); tick();
        enable = 1'b0;
        tick();
        chk("t37.abort_busy", a_busy, 0);
        chk("t37.abort_valid", a_valid, 0);
        result_ready = 1'b0;
        for (int t = 0; t < 8; t++) tick();
        chk("t37.idle_valid", a_valid, 0);

        // Reset during a running window
        enable = 1'b1; win_len = 8'd8; spikes_in = 3'b011;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check_reset_values("t38a");
        tick();
        enable = 1'b0; reset = 1'b0;
        for (int t = 0; t < 12; t++) tick();
        chk("t38a.no_valid", a_valid, 0);

        // Reset while a result is held
        enable = 1'b1; win_len = 8'd3; spikes_in = 3'b100;
        for (int t = 0; t <= 3; t++) tick();
        chk("t38b.held", a_valid, 1);
        reset = 1'b1;
        #1;
        check_reset_values("t38b");
        tick();
        enable = 1'b0; reset = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        chk("t38b.no_valid", a_valid, 0);

        // Spikes arriving while held are ignored (and counted when enabled)
        enable = 1'b1; win_len = 8'd2; spikes_in = 3'd0;
        tick();
        spikes_in = 3'b001;
        tick(); tick();
        enable = 1'b0; result_ready = 1'b0; spikes_in = 3'b111;
        for (int t = 0; t < 6; t++) tick();
        chk("t39.count0", a_c0, 2);
        chk("t39.count1", a_c1, 0);
        chk("t39.winner", a_win, 0);
`ifdef SPIKE_RATE_DECODER_DROP_CNT_EN
        chk("t39.dropped", a_drop, 6);
`endif
        release_result();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of each per-neuron spike counter.
REQ-002 SHALL have parameter WIN_W, default 8, the width of the window-length input and the remaining-cycle counter.
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port spikes_in  input  3  output spikes of the second network layer, synchronous to clk, one bit per neuron.
REQ-006 SHALL have port win_len  input  WIN_W  window length in cycles, sampled only at window start.
REQ-007 SHALL have port enable  input  1  request to run windows; level-sensitive.
REQ-008 SHALL have port result_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port result_valid  output  1  result held and stable.
REQ-010 SHALL have port count0, count1, count2  output  CNT_W each  spike counts of neurons 0/1/2 for the last window.
REQ-011 SHALL have port winner  output  2  index of the neuron with the most spikes; 2'd3 means no spikes.
REQ-012 SHALL have port overflow  output  1  at least one counter saturated during the window.
REQ-013 SHALL have port busy  output  1  high in COUNT state.

Function
REQ-014 SHALL implement the FSM states IDLE, COUNT and HOLD.
REQ-015 IDLE: on an edge with enable=1 and win_len!=0 (start edge T), SHALL latch win_len into remaining, clear the counters and overflow, and go to COUNT; with win_len=0 it SHALL stay in IDLE.
REQ-016 COUNT: spikes_in SHALL be sampled at edges T+1 through T+win_len inclusive, giving exactly win_len samples.
REQ-017 COUNT: at each sampled edge, each counter i SHALL increment when spikes_in[i]=1, saturating at 2^CNT_W-1.
REQ-018 COUNT: a sample that would exceed 2^CNT_W-1 SHALL set overflow, which stays set until the next window start.
REQ-019 COUNT: on the edge carrying the last sample, the FSM SHALL go to HOLD, with counts including that sample and result_valid=1 immediately after that edge.
REQ-020 COUNT: if enable=0 at any COUNT edge, SHALL abort to IDLE without asserting result_valid; that edge's sample is discarded and the counts are don't-care.
REQ-021 winner SHALL be registered together with the counts: the highest count, ties go to the lowest index, and all-zero counts give 2'd3.
REQ-022 HOLD: count0-2, winner and overflow SHALL remain stable while result_valid=1, and spikes_in SHALL be ignored.
REQ-023 HOLD: on an edge with result_ready=1, result_valid SHALL drop.
REQ-024 HOLD: if enable=1 and win_len!=0 on that same edge, SHALL treat it as a new start edge (direct HOLD to COUNT, back-to-back); otherwise SHALL go to IDLE.
REQ-025 result_ready while result_valid=0 SHALL have no effect.
REQ-026 busy SHALL equal (state==COUNT).
REQ-027 SHALL be purely synchronous apart from reset, with no combinational path from any input to any output.

Reset
REQ-028 While reset=1, SHALL force state=IDLE, counters=0, remaining=0, winner=2'd3, overflow=0, result_valid=0 and busy=0.
REQ-029 Reset asserted mid-COUNT or mid-HOLD SHALL discard the window or pending result; no result_valid SHALL follow release.
REQ-030 After reset release, the first start SHALL require a fresh edge with enable=1 while in IDLE.

Configuration
REQ-031 With macro SPIKE_RATE_DECODER_DROP_CNT_EN defined, SHALL add output port dropped  output  8  saturating count of HOLD-state edges where spikes_in!=0.
REQ-032 dropped SHALL be cleared only by reset.
REQ-033 Without SPIKE_RATE_DECODER_DROP_CNT_EN, port dropped and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Run win_len=10, enable=1, spikes_in=3'b001 on every sampled edge and 3'b100 on 4 of them, result_ready=0 -> result_valid rises exactly 10 edges after start; count0=10, count1=0, count2=4, winner=0, overflow=0; outputs held for 5 extra cycles.
REQ-035 Run a window where count1=count2=7 and count0=3 -> winner=1; a window with no spikes -> winner=3 and all counts 0.
REQ-036 Run CNT_W=8, win_len=255 with spikes_in=3'b010 constant, then a second run with CNT_W=4, win_len=20 -> first run gives count1=255, overflow=0; second run gives count1=15, overflow=1.
REQ-037 Hold result_ready=1 and enable=1 continuously with win_len=5 -> result_valid pulses one cycle every 6 edges with no idle gap (back-to-back); then drop enable for 1 cycle mid-window -> no result_valid, return to IDLE.
REQ-038 Assert reset at edge 3 of a win_len=8 window, then assert reset while in HOLD -> all outputs read reset values, and no result_valid follows either release.
REQ-039 With SPIKE_RATE_DECODER_DROP_CNT_EN defined, apply spikes_in=3'b111 for 6 HOLD cycles -> dropped=6, and counts unchanged.
